// File: rtl/fsb_arb_pkg.sv
// Shared types for the FSB master arbiter: arbiter state and the default packet shape.
package fsb_arb_pkg;

    localparam int unsigned FSB_WIDTH = 80;

    typedef logic [FSB_WIDTH-1:0] fsb_pkt_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage : fsb_arb_pkg

// File: rtl/fsb_arb_rr_pick.sv
// Combinational round-robin picker.
// Scans last_i+1, last_i+2, ... (mod num_req_p) and returns the first eligible index.
//   elig_i     : eligible requesters
//   last_i     : index the scan starts after
//   grant_v_o  : some requester is eligible
//   grant_oh_o : one-hot grant
//   grant_id_o : binary grant
module fsb_arb_rr_pick #(
    parameter int unsigned num_req_p  = 4,
    parameter int unsigned id_width_p = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]  elig_i,
    input  logic [id_width_p-1:0] last_i,
    output logic                  grant_v_o,
    output logic [num_req_p-1:0]  grant_oh_o,
    output logic [id_width_p-1:0] grant_id_o
);

    logic                  found;
    logic [id_width_p-1:0] idx;

    // First hit wins; later hits are masked by found.
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        grant_id_o = '0;
        grant_oh_o = '0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            idx = id_width_p'((32'(last_i) + k) % num_req_p);
            if (!found && elig_i[idx]) begin
                found      = 1'b1;
                grant_id_o = idx;
            end
        end
        if (found) begin
            grant_oh_o[grant_id_o] = 1'b1;
        end
    end

    assign grant_v_o = found;

endmodule : fsb_arb_rr_pick

// File: rtl/fsb_master_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one FSB master path among
// num_req_p requesters, through a one-entry registered output buffer.
//   clk_i, reset_n_i : clock, async active-low reset
//   en_i, req_v_i    : per-requester enable and packet valid
//   req_data_i       : packed requester packets, requester i at [fsb_width_p*i +: fsb_width_p]
//   req_yumi_o       : packet taken from requester i this cycle (combinational)
//   fsb_v_o, fsb_data_o, grant_id_o : buffered packet, its valid and source index
//   fsb_yumi_i       : downstream consumed the buffered packet
module fsb_master_arbiter
    import fsb_arb_pkg::*;
#(
    parameter int unsigned fsb_width_p = FSB_WIDTH,
    parameter int unsigned num_req_p   = 4,
    parameter int unsigned burst_len_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             en_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*fsb_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic                             fsb_v_o,
    output logic [fsb_width_p-1:0]           fsb_data_o,
    input  logic                             fsb_yumi_i,
    output logic [$clog2(num_req_p)-1:0]     grant_id_o
);

    localparam int unsigned ID_W  = $clog2(num_req_p);
    localparam int unsigned CNT_W = $clog2(burst_len_p + 1);

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [ID_W-1:0]        gnt_q, gnt_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   fsb_v_q, fsb_v_d;
    logic [fsb_width_p-1:0] fsb_data_q, fsb_data_d;

    logic [num_req_p-1:0]   elig, gnt_oh, pick_oh, sel_oh;
    logic [ID_W-1:0]        scan_from, pick_id, sel_id;
    logic [fsb_width_p-1:0] sel_data;
    logic                   load, keep, pick_v, sel_v, consume;

    assign elig = req_v_i & en_i;
    assign load = ~fsb_v_q | fsb_yumi_i;

    // While locked the grantee is the most recently served requester, so rotation
    // starts after it; once idle, last_q already holds that index.
    assign scan_from = (state_q == LOCKED) ? gnt_q : last_q;

    fsb_arb_rr_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (ID_W)
    ) u_rr_pick (
        .elig_i     (elig),
        .last_i     (scan_from),
        .grant_v_o  (pick_v),
        .grant_oh_o (pick_oh),
        .grant_id_o (pick_id)
    );

    // Grantee one-hot for the keep path.
    always_comb begin
        gnt_oh        = '0;
        gnt_oh[gnt_q] = 1'b1;
    end

    assign keep    = (state_q == LOCKED) && elig[gnt_q] && (cnt_q < CNT_W'(burst_len_p));
    assign sel_v   = keep | pick_v;
    assign sel_oh  = keep ? gnt_oh : pick_oh;
    assign sel_id  = keep ? gnt_q : pick_id;
    assign consume = reset_n_i & load & sel_v;

    assign req_yumi_o = consume ? sel_oh : '0;

    // One-hot AND-OR data mux.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            sel_data = sel_data | ({fsb_width_p{sel_oh[i]}} & req_data_i[i*fsb_width_p +: fsb_width_p]);
        end
    end

    // Next state, burst count, pointers and output buffer; nothing moves on a stall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        fsb_v_d    = fsb_v_q;
        fsb_data_d = fsb_data_q;
        grant_id_d = grant_id_q;
        if (consume) begin
            fsb_v_d    = 1'b1;
            fsb_data_d = sel_data;
            grant_id_d = sel_id;
            state_d    = LOCKED;
            if (keep) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
                gnt_d = sel_id;
                if (state_q == LOCKED) begin
                    last_d = gnt_q;
                end
            end
        end else if (load) begin
            fsb_v_d = 1'b0;
            if (state_q == LOCKED) begin
                state_d = IDLE;
                last_d  = gnt_q;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= ID_W'(num_req_p - 1);
            gnt_q      <= '0;
            grant_id_q <= '0;
            fsb_v_q    <= 1'b0;
            fsb_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            grant_id_q <= grant_id_d;
            fsb_v_q    <= fsb_v_d;
            fsb_data_q <= fsb_data_d;
        end
    end

    assign fsb_v_o    = fsb_v_q;
    assign fsb_data_o = fsb_data_q;
    assign grant_id_o = grant_id_q;

    // Downstream must not consume an empty buffer.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fsb_yumi_i |-> fsb_v_q);

endmodule : fsb_master_arbiter
